key_click_counter: RTL and testbench
====================================

# key_click_counter

Groups debounced key-press strobes into bursts and reports how many presses each burst contained (single, double, triple click, ...). Sits directly downstream of `debouncer` and consumes its `key_pressed_stb_o`. A burst ends when no new press arrives within a programmable window. At that point the block emits the press count with a one-cycle valid strobe for the control logic.

## Interface
- `CLK_FREQ_MHZ`, 50: clock frequency in MHz.
- `CLICK_WINDOW_US`, 300000: inactivity window in µs that closes a burst. Derived `WINDOW_CLK = CLK_FREQ_MHZ*CLICK_WINDOW_US`, must be ≥ 2.
- `MAX_CLICKS`, 7: saturation value of the press count. Must be ≥ 1.
- Derived `CNT_W = $clog2(MAX_CLICKS+1)` and `TMR_W = $clog2(WINDOW_CLK+1)`.

Ports (clock and reset first):
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; one clock, reset is asynchronous and active-low.
- `key_pressed_stb_i`  in  1  press strobe from `debouncer`.
- `click_cnt_o`  out  CNT_W  press count of the last completed burst. Held until the next emission.
- `click_valid_o`  out  1  one-cycle strobe; `click_cnt_o` is valid in that cycle.
- `busy_o`  out  1  high while a burst is open (state COUNT).

## Operation
- Input edge detect: register `stb_d`. A press is `key_pressed_stb_i & ~stb_d`. A strobe held high for N cycles counts as one press.
- FSM states: IDLE and COUNT.
- IDLE, on a press:
  - `cnt <= 1`, `tmr <= WINDOW_CLK-1`, go to COUNT.
- COUNT, on a press:
  - `cnt <= min(cnt+1, MAX_CLICKS)`; saturates and never wraps.
  - `tmr <= WINDOW_CLK-1`; the window restarts even when the count is saturated.
- COUNT, no press, `tmr != 0`: `tmr <= tmr-1`.
- COUNT, no press, `tmr == 0`:
  - `click_cnt_o <= cnt`, `click_valid_o <= 1` for exactly one cycle.
  - `cnt <= 0`, go to IDLE.
- Simultaneous press and `tmr == 0`: the press wins. It is counted, the timer reloads, and there is no emission.
- A press sampled in the cycle IDLE is entered after an emission starts a new burst with count 1.
- Reset (asynchronous, any time including mid-burst):
  - state IDLE, `cnt`, `tmr`, `stb_d` = 0.
  - `click_cnt_o` = 0, `click_valid_o` = 0, `busy_o` = 0.
  - The partial burst is discarded and never emitted.

## Timing
- Last press sampled at rising edge t: `click_valid_o` rises at edge t+WINDOW_CLK and falls at edge t+WINDOW_CLK+1.
- A press sampled at any edge t+1 … t+WINDOW_CLK extends the burst.
- `busy_o` rises at edge t+1 after the first press. It falls at the same edge where `click_valid_o` rises.
- All outputs are registered. There is no combinational path from input to output.
- `click_valid_o` is never high on two consecutive cycles. The minimum spacing between emissions is WINDOW_CLK+1 cycles.

## Structure
- Package `key_click_pkg`: `typedef enum logic {IDLE, COUNT} click_state_t`.
- Single module, no sub-modules. The timer is an inline down-counter of width TMR_W.
- Target size: about 120–150 lines of RTL.

## Test plan
All scenarios use bench parameters `CLK_FREQ_MHZ=1`, `CLICK_WINDOW_US=20` (so `WINDOW_CLK=20`) and `MAX_CLICKS=3`.
- Single press:
  - Stimulus: one-cycle strobe sampled at edge 10.
  - Required: `click_valid_o` high only at edges 30–31, `click_cnt_o=1`, `busy_o` high from edge 11 to edge 30.
- Triple press:
  - Stimulus: strobes at edges 10, 15, 20.
  - Required: one emission at edge 40 with `click_cnt_o=3`, no emission before it.
- Saturation:
  - Stimulus: 5 strobes spaced 10 cycles apart, starting at edge 10.
  - Required: one emission at edge 70 with `click_cnt_o=3`.
- Collision:
  - Stimulus: strobe at edge 10, then a second strobe at edge 30.
  - Required: no emission at edge 30; emission at edge 50 with `click_cnt_o=2`.
- Held strobe:
  - Stimulus: strobe held high at edges 10–17.
  - Required: emission at edge 30 with `click_cnt_o=1`.
- Reset mid-burst:
  - Stimulus: strobes at 10 and 15, `rst_ni` low at edge 22 for 3 cycles, then a strobe at 40.
  - Required: no emission before 60; at edge 60 `click_cnt_o=1`; all outputs are 0 while reset is low.

Source files
------------

// File: rtl/key_click_pkg.sv
// rtl/key_click_pkg.sv - shared types for the key click burst counter
package key_click_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } click_state_t;

endpackage

// File: rtl/key_click_counter.sv
// rtl/key_click_counter.sv - groups debounced key presses into bursts and reports the press count
module key_click_counter
  import key_click_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ    = 50,
  parameter int unsigned CLICK_WINDOW_US = 300000,
  parameter int unsigned MAX_CLICKS      = 7,
  localparam int unsigned WINDOW_CLK     = CLK_FREQ_MHZ * CLICK_WINDOW_US,
  localparam int unsigned CNT_W          = $clog2(MAX_CLICKS + 1),
  localparam int unsigned TMR_W          = $clog2(WINDOW_CLK + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_pressed_stb_i,
  output logic [CNT_W-1:0] click_cnt_o,
  output logic             click_valid_o,
  output logic             busy_o
);

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(WINDOW_CLK - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_CLICKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  click_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             stb_d;
  logic             press;
  logic             emit;

  // A strobe held high over several cycles is a single press.
  assign press = key_pressed_stb_i & ~stb_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          cnt_d   = CNT_ONE;
          tmr_d   = TMR_RELOAD;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // A press arriving on the last window cycle extends the burst instead of closing it.
        if (press) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          tmr_d = TMR_RELOAD;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_ONE;
        end else begin
          emit    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      stb_d         <= 1'b0;
      click_cnt_o   <= '0;
      click_valid_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      stb_d         <= key_pressed_stb_i;
      click_valid_o <= emit;
      if (emit) begin
        click_cnt_o <= cnt_q;
      end
      // Rises one cycle after the burst opens and drops together with the emission strobe.
      busy_o        <= (state_q == COUNT) && (state_d == COUNT);
    end
  end

endmodule

// File: tb/tb_key_click_counter.sv
// tb/tb_key_click_counter.sv - scoreboard bench for key_click_counter
module tb_key_click_counter;

  logic       clk_i_tb = 1'b0;
  logic       rst_n_tb;
  logic       stb_tb;
  logic [1:0] click_cnt;
  logic       click_valid;
  logic       busy;

  always #5 clk_i_tb = ~clk_i_tb;

  key_click_counter #(
    .CLK_FREQ_MHZ    (1),
    .CLICK_WINDOW_US (20),
    .MAX_CLICKS      (3)
  ) dut (
    .clk_i             (clk_i_tb),
    .rst_ni            (rst_n_tb),
    .key_pressed_stb_i (stb_tb),
    .click_cnt_o       (click_cnt),
    .click_valid_o     (click_valid),
    .busy_o            (busy)
  );

  typedef struct {
    int edge_n;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   base  = 0;

  always @(posedge clk_i_tb) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc - base);
    end
  endtask

  // Monitor: every emission is matched against the oldest expected one.
  always @(negedge clk_i_tb) begin
    if (click_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_emission: got cnt %0d at cycle %0d required none", click_cnt, cyc - base);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("emit_edge", cyc - base, e.edge_n - base);
        check("emit_cnt", click_cnt, e.cnt);
      end
    end
  end

  task automatic to_cyc(input int k);
    while (cyc < base + k) @(negedge clk_i_tb);
  endtask

  task automatic press(input int e);
    to_cyc(e - 1);
    stb_tb = 1'b1;
    to_cyc(e);
    stb_tb = 1'b0;
  endtask

  task automatic start_scn();
    rst_n_tb = 1'b0;
    @(negedge clk_i_tb);
    @(negedge clk_i_tb);
    rst_n_tb = 1'b1;
    @(negedge clk_i_tb);
    base = cyc;
  endtask

  task automatic expect_emit(input int e, input int c);
    exp_q.push_back('{base + e, c});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n_tb = 1'b0;
    stb_tb   = 1'b0;
    repeat (3) @(negedge clk_i_tb);
    check("reset_cnt", click_cnt, 0);
    check("reset_valid", click_valid, 0);
    check("reset_busy", busy, 0);
    rst_n_tb = 1'b1;

    // single press
    start_scn();
    expect_emit(30, 1);
    press(10);
    check("single_busy_e10", busy, 0);
    to_cyc(11);
    check("single_busy_e11", busy, 1);
    to_cyc(29);
    check("single_busy_e29", busy, 1);
    to_cyc(30);
    check("single_busy_e30", busy, 0);
    to_cyc(31);
    check("single_valid_e31", click_valid, 0);
    to_cyc(40);
    check("single_cnt_held", click_cnt, 1);

    // triple press
    start_scn();
    expect_emit(40, 3);
    press(10);
    press(15);
    press(20);
    to_cyc(50);

    // saturation with window restart on every press
    start_scn();
    expect_emit(70, 3);
    for (int i = 0; i < 5; i++) press(10 + 10 * i);
    to_cyc(80);

    // press on the last window cycle wins over emission
    start_scn();
    expect_emit(50, 2);
    press(10);
    press(30);
    to_cyc(60);

    // strobe held high for eight cycles
    start_scn();
    expect_emit(30, 1);
    to_cyc(9);
    stb_tb = 1'b1;
    to_cyc(17);
    stb_tb = 1'b0;
    to_cyc(40);

    // reset mid-burst discards the partial burst
    start_scn();
    expect_emit(60, 1);
    press(10);
    press(15);
    to_cyc(21);
    rst_n_tb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rst_mid_cnt", click_cnt, 0);
      check("rst_mid_valid", click_valid, 0);
      check("rst_mid_busy", busy, 0);
      @(negedge clk_i_tb);
    end
    rst_n_tb = 1'b1;
    press(40);
    to_cyc(70);

    check("pending_emissions", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
